// File: rtl/abro_cond_pkg.sv
// Shared types and constants for the ABRO input conditioner.
package abro_cond_pkg;

  // Gray-style encoding: the upper bit equals the registered clean level.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b11,
    CHECK_LOW   = 2'b10
  } debounce_state_t;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/abro_debounce_channel.sv
// One conditioner channel: 2-flop synchronizer, debounce FSM with stability
// counter, registered clean level and one-cycle rising-edge pulse.
// With ABRO_COND_GLITCH_CNT_EN defined, also a saturating glitch counter.
module abro_debounce_channel
  import abro_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_i,
`ifdef ABRO_COND_GLITCH_CNT_EN
  output logic [GLITCH_W-1:0] glitch_cnt_o,
`endif
  output logic                clean_o,
  output logic                rise_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            s1_q;
  logic            s2_q;
  debounce_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            clean_q;
  logic            rise_q;

  // Two-flop synchronizer; cleared by reset so a held input is re-accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Debounce FSM: a level change is accepted after DEBOUNCE_CYCLES equal samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      case (state_q)
        STABLE_LOW: begin
          if (s2_q) begin
            state_q <= CHECK_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!s2_q) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s2_q) begin
            state_q <= CHECK_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        CHECK_LOW: begin
          if (s2_q) begin
            state_q <= STABLE_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE_LOW;
          cnt_q   <= '0;
          clean_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ABRO_COND_GLITCH_CNT_EN
  logic                glitch_evt;
  logic [GLITCH_W-1:0] glitch_q;

  // A check phase aborted back to the prior stable level is one glitch.
  assign glitch_evt = ((state_q == CHECK_HIGH) && !s2_q) ||
                      ((state_q == CHECK_LOW)  &&  s2_q);

  // Saturating glitch counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_q <= '0;
    end else if (glitch_evt && (glitch_q != {GLITCH_W{1'b1}})) begin
      glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign glitch_cnt_o = glitch_q;
`endif

  assign clean_o = clean_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/abro_input_conditioner.sv
// ABRO front-end: three independent debounce channels for A, B and R.
// Optional feature macro: ABRO_COND_GLITCH_CNT_EN adds glitch_cnt
// ({R,B,A} 8-bit saturating glitch counters).
module abro_input_conditioner
  import abro_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_raw,
  input  logic        b_raw,
  input  logic        r_raw,
  output logic        A_clean,
  output logic        B_clean,
  output logic        R_clean,
  output logic        a_rise,
  output logic        b_rise,
`ifdef ABRO_COND_GLITCH_CNT_EN
  output logic [23:0] glitch_cnt,
`endif
  output logic        r_rise
);

`ifdef ABRO_COND_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] gl_a;
  logic [GLITCH_W-1:0] gl_b;
  logic [GLITCH_W-1:0] gl_r;
  assign glitch_cnt = {gl_r, gl_b, gl_a};
`endif

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_a (
    .clk          (clk),
    .reset        (reset),
    .raw_i        (a_raw),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt_o (gl_a),
`endif
    .clean_o      (A_clean),
    .rise_o       (a_rise)
  );

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_b (
    .clk          (clk),
    .reset        (reset),
    .raw_i        (b_raw),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt_o (gl_b),
`endif
    .clean_o      (B_clean),
    .rise_o       (b_rise)
  );

  abro_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_r (
    .clk          (clk),
    .reset        (reset),
    .raw_i        (r_raw),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt_o (gl_r),
`endif
    .clean_o      (R_clean),
    .rise_o       (r_rise)
  );

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Self-checking bench for abro_input_conditioner (DEBOUNCE_CYCLES=4).
// Reference model: per channel, a 2-sample input delay followed by a run
// length of samples disagreeing with the accepted level.
module tb_abro_input_conditioner;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset;
  logic a_raw, b_raw, r_raw;
  logic A_clean, B_clean, R_clean;
  logic a_rise, b_rise, r_rise;
`ifdef ABRO_COND_GLITCH_CNT_EN
  logic [23:0] glitch_cnt;
`endif

  abro_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_raw      (a_raw),
    .b_raw      (b_raw),
    .r_raw      (r_raw),
    .A_clean    (A_clean),
    .B_clean    (B_clean),
    .R_clean    (R_clean),
    .a_rise     (a_rise),
    .b_rise     (b_rise),
`ifdef ABRO_COND_GLITCH_CNT_EN
    .glitch_cnt (glitch_cnt),
`endif
    .r_rise     (r_rise)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0=A, 1=B, 2=R.
  int m_s1   [3];
  int m_s2   [3];
  int m_lvl  [3];
  int m_run  [3];
  int m_rise [3];
  int m_gl   [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge(input logic rst, input logic [2:0] raw);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
        m_run[i] = 0; m_rise[i] = 0; m_gl[i] = 0;
      end else begin
        m_rise[i] = 0;
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_lvl[i]  = m_s2[i];
            m_rise[i] = m_lvl[i];
            m_run[i]  = 0;
          end
        end else begin
          if (m_run[i] > 0 && m_gl[i] < 255) m_gl[i]++;
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(raw[i]);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("A_clean", {31'd0, A_clean}, m_lvl[0]);
    check_eq("B_clean", {31'd0, B_clean}, m_lvl[1]);
    check_eq("R_clean", {31'd0, R_clean}, m_lvl[2]);
    check_eq("a_rise",  {31'd0, a_rise},  m_rise[0]);
    check_eq("b_rise",  {31'd0, b_rise},  m_rise[1]);
    check_eq("r_rise",  {31'd0, r_rise},  m_rise[2]);
`ifdef ABRO_COND_GLITCH_CNT_EN
    check_eq("glitch_a", {24'd0, glitch_cnt[7:0]},   m_gl[0]);
    check_eq("glitch_b", {24'd0, glitch_cnt[15:8]},  m_gl[1]);
    check_eq("glitch_r", {24'd0, glitch_cnt[23:16]}, m_gl[2]);
`endif
  endtask

  task automatic step(input logic rst, input logic a, input logic b, input logic r);
    reset = rst; a_raw = a; b_raw = b; r_raw = r;
    @(posedge clk);
    model_edge(rst, {r, b, a});
    #1;
    compare_all();
  endtask

  function automatic logic get_clean(input int ch);
    case (ch)
      0:       return A_clean;
      1:       return B_clean;
      default: return R_clean;
    endcase
  endfunction

  // Hold inputs until channel ch reaches level, returning edges taken (bounded).
  task automatic run_until(input int ch, input logic level, input logic a,
                           input logic b, input logic r, output int n);
    n = 0;
    do begin
      step(1'b0, a, b, r);
      n++;
    end while (get_clean(ch) !== level && n < 20);
  endtask

  int  n;
  int  pulses;
  logic [2:0] cur;
  int  hold [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
      m_run[i] = 0; m_rise[i] = 0; m_gl[i] = 0;
    end
    reset = 1'b1; a_raw = 1'b1; b_raw = 1'b1; r_raw = 1'b1;

    // Reset with all raw inputs high; then a full acceptance after release.
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("reset_A_clean", {31'd0, A_clean}, 32'd0);
    check_eq("reset_a_rise",  {31'd0, a_rise},  32'd0);
    run_until(0, 1'b1, 1'b1, 1'b1, 1'b1, n);
    check_eq("release_latency", n, 6);
    check_eq("release_a_rise", {31'd0, a_rise}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("rise_one_cycle", {31'd0, a_rise}, 32'd0);

    // Fall on A: same latency, never a pulse.
    pulses = 0;
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      n++;
      if (a_rise) pulses++;
    end while (A_clean !== 1'b0 && n < 20);
    check_eq("fall_latency", n, 6);
    check_eq("fall_no_pulse", pulses, 0);

    // Bring everything low and settle.
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Clean rise on A alone.
    run_until(0, 1'b1, 1'b1, 1'b0, 1'b0, n);
    check_eq("rise_latency", n, 6);
    repeat (14) step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("rise_B_quiet", {31'd0, B_clean}, 32'd0);
    check_eq("rise_R_quiet", {31'd0, R_clean}, 32'd0);

    // Bounce on B, then hold: exactly one pulse, 6 edges after hold start.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (b_rise) begin
        pulses++;
        if (n == 0) n = k + 1;
      end
    end
    check_eq("bounce_pulses", pulses, 1);
    check_eq("bounce_latency", n, 6);
`ifdef ABRO_COND_GLITCH_CNT_EN
    check_eq("bounce_glitches", {24'd0, glitch_cnt[15:8]}, 32'd2);
`endif

    // Short glitch on R: never accepted.
    pulses = 0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (r_rise || R_clean) pulses++;
    end
    check_eq("short_glitch_r", pulses, 0);

    // Simultaneous A and B rise.
    run_until(0, 1'b1, 1'b1, 1'b1, 1'b0, n);
    check_eq("simul_a_latency", n, 6);
    check_eq("simul_b_rise", {31'd0, b_rise}, 32'd1);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset pulsed while A is mid-check: no pulse, acceptance restarts.
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("midcheck_reset_clean", {31'd0, A_clean}, 32'd0);
    run_until(0, 1'b1, 1'b1, 1'b0, 1'b0, n);
    check_eq("midcheck_restart_latency", n, 6);

    // Randomized hold lengths around the debounce threshold, rare resets.
    cur = 3'b000;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 8);
        end
        hold[i]--;
      end
      step(($urandom_range(0, 199) == 0), cur[0], cur[1], cur[2]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
